// File: rtl/mips_regfile_arb_pkg.sv
// Shared types and constants for the register-file arbiter.
package mips_regfile_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Requester indices into the two-bit request/grant vectors
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  typedef enum logic [1:0] {
    OPEN     = 2'd0,
    LOCKED_A = 2'd1,
    LOCKED_B = 2'd2
  } lock_state_t;

endpackage

// File: rtl/mips_rr_arb2.sv
// Two-way picker: round-robin or fixed priority to A. The pointer flips
// to the loser after every grant. An external override lets the lock
// timeout hand the next turn to the starved side.
module mips_rr_arb2
  import mips_regfile_arb_pkg::*;
#(
  parameter int FIXED_PRIO_A = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,       // already masked by eligibility
  input  logic       ptr_set,   // override the pointer this edge
  input  logic       ptr_val,   // 0 = favour A, 1 = favour B
  output logic [1:0] gnt,
  output logic       ptr
);

  // Pick at most one requester
  always_comb begin
    gnt = 2'b00;
    if (req[REQ_A] && req[REQ_B]) begin
      if (FIXED_PRIO_A != 0 || !ptr) gnt[REQ_A] = 1'b1;
      else                           gnt[REQ_B] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // Pointer update: override first, else move away from the winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ptr <= 1'b0;
    else if (ptr_set)      ptr <= ptr_val;
    else if (gnt[REQ_A])   ptr <= 1'b1;
    else if (gnt[REQ_B])   ptr <= 1'b0;
  end

endmodule

// File: rtl/mips_regfile_arbiter.sv
// Serialises requester A (datapath) and B (debug/loader) onto the single
// port of the register file: one two-register read or one write per
// cycle, with exclusive locking and a starvation timeout.
module mips_regfile_arbiter
  import mips_regfile_arb_pkg::*;
#(
  parameter int MAX_LOCK         = 64,
  parameter int FIXED_PRIO_A     = 0,
  parameter int ZERO_REG_PROTECT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        b_req,
  input  logic        a_we,
  input  logic        b_we,
  input  logic        a_lock,
  input  logic        b_lock,
  input  logic [4:0]  a_rs,
  input  logic [4:0]  a_rt,
  input  logic [4:0]  b_rs,
  input  logic [4:0]  b_rt,
  input  logic [4:0]  a_rd,
  input  logic [4:0]  b_rd,
  input  logic [31:0] a_wdata,
  input  logic [31:0] b_wdata,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_rvalid,
  output logic        b_rvalid,
  output logic [31:0] a_rdata1,
  output logic [31:0] a_rdata2,
  output logic [31:0] b_rdata1,
  output logic [31:0] b_rdata2,
  output logic [4:0]  rf_read_reg_1,
  output logic [4:0]  rf_read_reg_2,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        rf_reg_write,
  input  logic [31:0] rf_read_data_1,
  input  logic [31:0] rf_read_data_2,
  output logic        lock_timeout
);

  localparam int TW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [TW-1:0] TMAX = TW'(MAX_LOCK - 1);

  lock_state_t state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic blk_a, blk_a_nx, blk_b, blk_b_nx;
  logic timeout_nx;
  logic ptr_set, ptr_val, ptr;
  logic elig_a, elig_b;
  logic [1:0] req_v, gnt;

  // Granted request fields
  logic                  sel_we;
  logic [REG_ADDR_W-1:0] sel_rs, sel_rt, sel_rd;
  logic [DATA_W-1:0]     sel_wdata;

  assign elig_a = (state != LOCKED_B);
  assign elig_b = (state != LOCKED_A);
  assign req_v  = {b_req & elig_b, a_req & elig_a};

  mips_rr_arb2 #(.FIXED_PRIO_A(FIXED_PRIO_A)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_v),
    .ptr_set (ptr_set),
    .ptr_val (ptr_val),
    .gnt     (gnt),
    .ptr     (ptr)
  );

  assign a_gnt = gnt[REQ_A];
  assign b_gnt = gnt[REQ_B];

  // Mux the winner's operation fields
  always_comb begin
    sel_we    = a_we;
    sel_rs    = a_rs;
    sel_rt    = a_rt;
    sel_rd    = a_rd;
    sel_wdata = a_wdata;
    if (b_gnt) begin
      sel_we    = b_we;
      sel_rs    = b_rs;
      sel_rt    = b_rt;
      sel_rd    = b_rd;
      sel_wdata = b_wdata;
    end
  end

  // Drive the register file; idle port shows zeros. A write to r0 is
  // still granted but never reaches the file when protection is on.
  always_comb begin
    rf_read_reg_1 = '0;
    rf_read_reg_2 = '0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    rf_reg_write  = 1'b0;
    if (a_gnt || b_gnt) begin
      if (sel_we) begin
        rf_write_reg  = sel_rd;
        rf_write_data = sel_wdata;
        rf_reg_write  = !((ZERO_REG_PROTECT != 0) && (sel_rd == '0));
      end else begin
        rf_read_reg_1 = sel_rs;
        rf_read_reg_2 = sel_rt;
      end
    end
  end

  // Lock FSM next state, timer, block flags and timeout pointer override
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    timeout_nx = 1'b0;
    ptr_set    = 1'b0;
    ptr_val    = 1'b0;
    // a block flag only survives while its owner keeps lock asserted
    blk_a_nx   = blk_a & a_lock;
    blk_b_nx   = blk_b & b_lock;
    case (state)
      OPEN: begin
        timer_nx = '0;
        if (a_gnt && a_lock && !blk_a)      state_nx = LOCKED_A;
        else if (b_gnt && b_lock && !blk_b) state_nx = LOCKED_B;
      end
      LOCKED_A: begin
        if (!a_lock) begin
          state_nx = OPEN;
          timer_nx = '0;
        end else if (timer == TMAX) begin
          state_nx   = OPEN;
          timer_nx   = '0;
          timeout_nx = 1'b1;
          blk_a_nx   = 1'b1;
          ptr_set    = 1'b1;
          ptr_val    = 1'(REQ_B);
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      LOCKED_B: begin
        if (!b_lock) begin
          state_nx = OPEN;
          timer_nx = '0;
        end else if (timer == TMAX) begin
          state_nx   = OPEN;
          timer_nx   = '0;
          timeout_nx = 1'b1;
          blk_b_nx   = 1'b1;
          ptr_set    = 1'b1;
          ptr_val    = 1'(REQ_A);
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: begin
        state_nx = OPEN;
        timer_nx = '0;
      end
    endcase
  end

  // Lock FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= OPEN;
      timer        <= '0;
      blk_a        <= 1'b0;
      blk_b        <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      blk_a        <= blk_a_nx;
      blk_b        <= blk_b_nx;
      lock_timeout <= timeout_nx;
    end
  end

  // Read response flags: the file registers read data, so the owner
  // sees it exactly one cycle after the grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

  assign a_rdata1 = a_rvalid ? rf_read_data_1 : '0;
  assign a_rdata2 = a_rvalid ? rf_read_data_2 : '0;
  assign b_rdata1 = b_rvalid ? rf_read_data_1 : '0;
  assign b_rdata2 = b_rvalid ? rf_read_data_2 : '0;

endmodule

// File: tb/tb_mips_regfile_arbiter.sv
// Directed bench: main DUT with MAX_LOCK=8 driving a register file model,
// plus a long-lock instance and a fixed-priority instance on the same inputs.
module tb_mips_regfile_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a_req, b_req, a_we, b_we, a_lock, b_lock;
  logic [4:0] a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
  logic [31:0] a_wdata, b_wdata;

  logic a_gnt, b_gnt, a_rvalid, b_rvalid, rf_reg_write, lock_timeout;
  logic [31:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2, rf_write_data;
  logic [4:0] rf_read_reg_1, rf_read_reg_2, rf_write_reg;
  logic [31:0] rf_d1, rf_d2;

  // Secondary instance outputs (l_ = MAX_LOCK 64, f_ = fixed priority)
  logic l_a_gnt, l_b_gnt, l_arv, l_brv, l_rfw, l_to;
  logic [31:0] l_ad1, l_ad2, l_bd1, l_bd2, l_wd;
  logic [4:0] l_r1, l_r2, l_wr;
  logic f_a_gnt, f_b_gnt, f_arv, f_brv, f_rfw, f_to;
  logic [31:0] f_ad1, f_ad2, f_bd1, f_bd2, f_wd;
  logic [4:0] f_r1, f_r2, f_wr;

  mips_regfile_arbiter #(.MAX_LOCK(8), .FIXED_PRIO_A(0), .ZERO_REG_PROTECT(1)) dut (
    .clk(clk), .rst(rst), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_lock(a_lock), .b_lock(b_lock), .a_rs(a_rs), .a_rt(a_rt), .b_rs(b_rs), .b_rt(b_rt),
    .a_rd(a_rd), .b_rd(b_rd), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata1(a_rdata1), .a_rdata2(a_rdata2), .b_rdata1(b_rdata1), .b_rdata2(b_rdata2),
    .rf_read_reg_1(rf_read_reg_1), .rf_read_reg_2(rf_read_reg_2), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .rf_reg_write(rf_reg_write),
    .rf_read_data_1(rf_d1), .rf_read_data_2(rf_d2), .lock_timeout(lock_timeout));

  mips_regfile_arbiter #(.MAX_LOCK(64), .FIXED_PRIO_A(0), .ZERO_REG_PROTECT(1)) dut_l (
    .clk(clk), .rst(rst), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_lock(a_lock), .b_lock(b_lock), .a_rs(a_rs), .a_rt(a_rt), .b_rs(b_rs), .b_rt(b_rt),
    .a_rd(a_rd), .b_rd(b_rd), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(l_a_gnt), .b_gnt(l_b_gnt), .a_rvalid(l_arv), .b_rvalid(l_brv),
    .a_rdata1(l_ad1), .a_rdata2(l_ad2), .b_rdata1(l_bd1), .b_rdata2(l_bd2),
    .rf_read_reg_1(l_r1), .rf_read_reg_2(l_r2), .rf_write_reg(l_wr),
    .rf_write_data(l_wd), .rf_reg_write(l_rfw),
    .rf_read_data_1(32'h0), .rf_read_data_2(32'h0), .lock_timeout(l_to));

  mips_regfile_arbiter #(.MAX_LOCK(64), .FIXED_PRIO_A(1), .ZERO_REG_PROTECT(1)) dut_f (
    .clk(clk), .rst(rst), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_lock(a_lock), .b_lock(b_lock), .a_rs(a_rs), .a_rt(a_rt), .b_rs(b_rs), .b_rt(b_rt),
    .a_rd(a_rd), .b_rd(b_rd), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(f_a_gnt), .b_gnt(f_b_gnt), .a_rvalid(f_arv), .b_rvalid(f_brv),
    .a_rdata1(f_ad1), .a_rdata2(f_ad2), .b_rdata1(f_bd1), .b_rdata2(f_bd2),
    .rf_read_reg_1(f_r1), .rf_read_reg_2(f_r2), .rf_write_reg(f_wr),
    .rf_write_data(f_wd), .rf_reg_write(f_rfw),
    .rf_read_data_1(32'h0), .rf_read_data_2(32'h0), .lock_timeout(f_to));

  // Register file model: registered reads, writes on the edge, r0 not
  // hardwired so a leaked r0 write would show up on readback
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      regs[3] <= 32'h11;
      regs[4] <= 32'h22;
      rf_d1 <= 32'h0;
      rf_d2 <= 32'h0;
    end else begin
      if (rf_reg_write) regs[rf_write_reg] <= rf_write_data;
      rf_d1 <= regs[rf_read_reg_1];
      rf_d2 <= regs[rf_read_reg_2];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_lock = 0; b_lock = 0;
    a_rs = 0; a_rt = 0; a_rd = 0; b_rs = 0; b_rt = 0; b_rd = 0;
    a_wdata = 0; b_wdata = 0;
  endtask

  // Advance to just after the next rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    // ---- reset state
    @(posedge clk);
    #4;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_rf_we", rf_reg_write, 0);
    chk("rst_timeout", lock_timeout, 0);
    @(posedge clk);
    #1 rst = 0;

    // ---- single A read
    a_req = 1; a_rs = 3; a_rt = 4;
    #3;
    chk("rd_a_gnt", a_gnt, 1);
    chk("rd_b_gnt", b_gnt, 0);
    chk("rd_addr1", rf_read_reg_1, 3);
    chk("rd_addr2", rf_read_reg_2, 4);
    chk("rd_we", rf_reg_write, 0);
    nxt(); idle(); #3;
    chk("rd_rvalid", a_rvalid, 1);
    chk("rd_data1", a_rdata1, 32'h11);
    chk("rd_data2", a_rdata2, 32'h22);
    chk("rd_b_rvalid", b_rvalid, 0);
    nxt(); #3;
    chk("rd_rvalid_once", a_rvalid, 0);

    // ---- round-robin vs fixed priority, back-to-back reads
    do_reset();
    a_req = 1; b_req = 1; a_rs = 3; a_rt = 4; b_rs = 4; b_rt = 3;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("rr_a_gnt", a_gnt, (i % 2 == 0));
      chk("rr_b_gnt", b_gnt, (i % 2 == 1));
      chk("fp_a_gnt", f_a_gnt, 1);
      chk("fp_b_gnt", f_b_gnt, 0);
      if (i > 0) begin
        chk("rr_a_rvalid", a_rvalid, ((i - 1) % 2 == 0));
        chk("rr_b_rvalid", b_rvalid, ((i - 1) % 2 == 1));
      end
      nxt();
    end
    idle(); #3;
    chk("rr_b_last_rvalid", b_rvalid, 1);
    chk("rr_b_data1", b_rdata1, 32'h22);
    chk("rr_b_data2", b_rdata2, 32'h11);
    nxt();

    // ---- write then read, r0 protection, write not disturbing rvalid
    idle(); b_req = 1; b_we = 1; b_rd = 5; b_wdata = 32'hDEADBEEF;
    #3;
    chk("wr_b_gnt", b_gnt, 1);
    chk("wr_rf_we", rf_reg_write, 1);
    chk("wr_addr", rf_write_reg, 5);
    chk("wr_data", rf_write_data, 32'hDEADBEEF);
    nxt(); idle(); a_req = 1; a_rs = 5; a_rt = 3;
    #3;
    chk("raw_a_gnt", a_gnt, 1);
    chk("raw_b_rvalid", b_rvalid, 0);
    nxt(); idle(); b_req = 1; b_we = 1; b_rd = 0; b_wdata = 32'hFFFFFFFF;
    #3;
    chk("raw_rvalid", a_rvalid, 1);
    chk("raw_data1", a_rdata1, 32'hDEADBEEF);
    chk("raw_data2", a_rdata2, 32'h11);
    chk("r0_b_gnt", b_gnt, 1);
    chk("r0_rf_we", rf_reg_write, 0);
    nxt(); idle(); a_req = 1; a_rs = 0; a_rt = 5;
    #3;
    chk("r0_no_rvalid", b_rvalid, 0);
    nxt(); idle(); #3;
    chk("r0_read", a_rdata1, 32'h0);
    chk("r0_read_r5", a_rdata2, 32'hDEADBEEF);
    nxt();

    // ---- lock held 10 cycles (MAX_LOCK 64 instance)
    do_reset();
    a_req = 1; a_lock = 1; a_rs = 3;
    #3;
    chk("lk_a_gnt", l_a_gnt, 1);
    nxt();
    b_req = 1; b_rs = 4;
    for (int i = 0; i < 10; i++) begin
      #3;
      chk("lk_b_blocked", l_b_gnt, 0);
      chk("lk_a_held", l_a_gnt, 1);
      nxt();
    end
    a_lock = 0;
    #3;
    chk("lk_drop_b", l_b_gnt, 0);
    nxt(); #3;
    chk("lk_after_b", l_b_gnt, 1);
    chk("lk_after_a", l_a_gnt, 0);
    nxt();

    // ---- starvation timeout (MAX_LOCK 8 instance)
    do_reset();
    a_req = 1; a_lock = 1;
    #3;
    chk("to_lock_gnt", a_gnt, 1);
    nxt();
    b_req = 1;
    for (int i = 0; i < 8; i++) begin
      #3;
      chk("to_b_blocked", b_gnt, 0);
      chk("to_no_pulse", lock_timeout, 0);
      nxt();
    end
    #3;
    chk("to_pulse", lock_timeout, 1);
    chk("to_b_gnt", b_gnt, 1);
    chk("to_a_gnt", a_gnt, 0);
    nxt(); #3;
    chk("to_pulse_once", lock_timeout, 0);
    chk("to_a_turn", a_gnt, 1);
    nxt(); #3;
    chk("to_no_relock", b_gnt, 1);
    nxt();
    a_lock = 0; b_req = 0;
    #3;
    chk("to_unblock_gnt", a_gnt, 1);
    nxt();
    a_lock = 1;
    #3;
    chk("to_relock_gnt", a_gnt, 1);
    nxt();
    b_req = 1;
    #3;
    chk("to_relocked", b_gnt, 0);
    nxt(); idle(); nxt();

    // ---- reset right after a granted, locking read
    do_reset();
    a_req = 1; a_lock = 1; a_rs = 3; a_rt = 4;
    #3;
    chk("mr_a_gnt", a_gnt, 1);
    @(posedge clk);
    #1 rst = 1; idle();
    #3;
    chk("mr_rvalid", a_rvalid, 0);
    chk("mr_timeout", lock_timeout, 0);
    @(posedge clk);
    #1 rst = 0; b_req = 1;
    #3;
    chk("mr_open", b_gnt, 1);
    nxt(); idle();
    // pointer must come back to A after reset
    a_req = 1;
    #3;
    chk("mr2_a_gnt", a_gnt, 1);
    @(posedge clk);
    #1 rst = 1; idle();
    #3;
    chk("mr2_rvalid", a_rvalid, 0);
    @(posedge clk);
    #1 rst = 0; a_req = 1; b_req = 1;
    #3;
    chk("mr2_ptr_a", a_gnt, 1);
    chk("mr2_ptr_b", b_gnt, 0);
    nxt(); idle(); nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
